// File: rtl/circular_buffer_controller.sv
// Pointer/flag controller for a circular buffer over an external DEPTH-entry RAM.
// Write and read pointers are lap-tagged wrapping counters; all status is derived from them.
module circular_buffer_controller #(
  parameter int DEPTH                  = 4,
  parameter int ALMOST_FULL_THRESHOLD  = 3,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          flush,
  input  logic          write_enable,
  output logic [AW-1:0] write_address,
  input  logic          read_enable,
  output logic [AW-1:0] read_address,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          write_error,
  output logic          read_error
);

  // Pointer layout: {lap, index}; index runs 0..DEPTH-1 and the lap toggles on wrap.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        write_accept;
  logic        read_accept;

  function automatic logic [AW:0] ptr_inc(input logic [AW:0] ptr);
    logic [AW-1:0] idx;
    idx = ptr[AW-1:0];
    if (idx == AW'(DEPTH - 1)) ptr_inc = {~ptr[AW], {AW{1'b0}}};
    else                       ptr_inc = {ptr[AW], idx + AW'(1)};
  endfunction

  assign write_address = wr_ptr[AW-1:0];
  assign read_address  = rd_ptr[AW-1:0];

  assign empty = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] == rd_ptr[AW]);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Acceptance uses the registered flags only, so a read on a full buffer
  // cannot make room for a same-cycle write (and vice versa on empty).
  assign write_accept = write_enable && !full  && !flush;
  assign read_accept  = read_enable  && !empty && !flush;

  // NOTE: every path through an always_comb assigns its outputs, so no latch is inferred.
  always_comb begin
    if (wr_ptr[AW] == rd_ptr[AW])
      level = LW'(wr_ptr[AW-1:0]) - LW'(rd_ptr[AW-1:0]);
    else
      level = LW'(DEPTH) - LW'(rd_ptr[AW-1:0]) + LW'(wr_ptr[AW-1:0]);
  end

  assign almost_full  = (level >= LW'(ALMOST_FULL_THRESHOLD));
  assign almost_empty = (level <= LW'(ALMOST_EMPTY_THRESHOLD));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      write_error <= 1'b0;
      read_error  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (write_accept) wr_ptr <= ptr_inc(wr_ptr);
        if (read_accept)  rd_ptr <= ptr_inc(rd_ptr);
      end
      // A rejection caused by flush is not an error.
      write_error <= write_enable && full  && !flush;
      read_error  <= read_enable  && empty && !flush;
    end
  end

endmodule

// File: tb/tb_circular_buffer_controller.sv
// Self-checking bench for circular_buffer_controller (DEPTH=4): a count-based reference
// model pushes expected outputs into a scoreboard that is drained after each clock edge.
module tb_circular_buffer_controller;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic       flush;
  logic       write_enable;
  logic       read_enable;
  logic [1:0] write_address;
  logic [1:0] read_address;
  logic       empty;
  logic       full;
  logic [2:0] level;
  logic       almost_full;
  logic       almost_empty;
  logic       write_error;
  logic       read_error;

  circular_buffer_controller #(
    .DEPTH(DEPTH),
    .ALMOST_FULL_THRESHOLD(3),
    .ALMOST_EMPTY_THRESHOLD(1)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .flush(flush),
    .write_enable(write_enable),
    .write_address(write_address),
    .read_enable(read_enable),
    .read_address(read_address),
    .empty(empty),
    .full(full),
    .level(level),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .write_error(write_error),
    .read_error(read_error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] waddr;
    logic [1:0] raddr;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic       af;
    logic       ae;
    logic       werr;
    logic       rerr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: explicit occupancy count instead of lap bits.
  int m_wr, m_rd, m_count;
  logic m_werr, m_rerr;

  function automatic exp_t model_outputs();
    exp_t e;
    e.waddr = 2'(m_wr);
    e.raddr = 2'(m_rd);
    e.empty = (m_count == 0);
    e.full  = (m_count == DEPTH);
    e.level = 3'(m_count);
    e.af    = (m_count >= 3);
    e.ae    = (m_count <= 1);
    e.werr  = m_werr;
    e.rerr  = m_rerr;
    return e;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_count = 0; m_werr = 1'b0; m_rerr = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic re, input logic fl);
    logic wa, ra;
    wa = we && (m_count != DEPTH) && !fl;
    ra = re && (m_count != 0) && !fl;
    m_werr = we && (m_count == DEPTH) && !fl;
    m_rerr = re && (m_count == 0) && !fl;
    if (fl) begin
      m_wr = 0; m_rd = 0; m_count = 0;
    end else begin
      if (wa) m_wr = (m_wr + 1) % DEPTH;
      if (ra) m_rd = (m_rd + 1) % DEPTH;
      m_count = m_count + int'(wa) - int'(ra);
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed none expected entry", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, ".waddr"}, 8'(write_address), 8'(e.waddr));
    cmp({tag, ".raddr"}, 8'(read_address),  8'(e.raddr));
    cmp({tag, ".empty"}, 8'(empty),         8'(e.empty));
    cmp({tag, ".full"},  8'(full),          8'(e.full));
    cmp({tag, ".level"}, 8'(level),         8'(e.level));
    cmp({tag, ".afull"}, 8'(almost_full),   8'(e.af));
    cmp({tag, ".aempty"},8'(almost_empty),  8'(e.ae));
    cmp({tag, ".werr"},  8'(write_error),   8'(e.werr));
    cmp({tag, ".rerr"},  8'(read_error),    8'(e.rerr));
  endtask

  // One clock of stimulus: drive on the falling edge, compare 1 time unit after the rising edge.
  task automatic step(input string tag, input logic we, input logic re, input logic fl);
    @(negedge clock);
    write_enable = we;
    read_enable  = re;
    flush        = fl;
    model_step(we, re, fl);
    sb.push_back(model_outputs());
    @(posedge clock);
    #1;
    check_pop(tag);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    model_reset();
    #12;
    sb.push_back(model_outputs());
    check_pop("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Fill, then overflow once and confirm the error is a single-cycle pulse.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 1'b0);
    cmp("fill_full", 8'(full), 8'd1);
    step("overflow", 1'b1, 1'b0, 1'b0);
    cmp("overflow_werr", 8'(write_error), 8'd1);
    step("overflow_idle", 1'b0, 1'b0, 1'b0);

    // Drain, then underflow once.
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 1'b0);
    cmp("drain_empty", 8'(empty), 8'd1);
    step("underflow", 1'b0, 1'b1, 1'b0);
    cmp("underflow_rerr", 8'(read_error), 8'd1);
    step("underflow_idle", 1'b0, 1'b0, 1'b0);

    // Wrap: W W then (R W) x4 then R -> 6 writes, 5 reads.
    step("wrap", 1'b1, 1'b0, 1'b0);
    step("wrap", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("wrap", 1'b0, 1'b1, 1'b0);
      step("wrap", 1'b1, 1'b0, 1'b0);
    end
    step("wrap", 1'b0, 1'b1, 1'b0);
    cmp("wrap_level", 8'(level), 8'd1);
    cmp("wrap_widx", 8'(write_address), 8'd2);
    cmp("wrap_ridx", 8'(read_address), 8'd1);

    // Simultaneous write+read at level 2, at full and at empty.
    step("simul_prep", 1'b1, 1'b0, 1'b0);
    step("simul_mid", 1'b1, 1'b1, 1'b0);
    cmp("simul_mid_level", 8'(level), 8'd2);
    step("simul_prep", 1'b1, 1'b0, 1'b0);
    step("simul_prep", 1'b1, 1'b0, 1'b0);
    step("simul_full", 1'b1, 1'b1, 1'b0);
    cmp("simul_full_level", 8'(level), 8'd3);
    for (int i = 0; i < 3; i++) step("simul_prep", 1'b0, 1'b1, 1'b0);
    step("simul_empty", 1'b1, 1'b1, 1'b0);
    cmp("simul_empty_level", 8'(level), 8'd1);
    cmp("simul_empty_rerr", 8'(read_error), 8'd1);

    // Flush at level 3 with a write pending.
    step("flush_prep", 1'b1, 1'b0, 1'b0);
    step("flush_prep", 1'b1, 1'b0, 1'b0);
    step("flush", 1'b1, 1'b0, 1'b1);
    cmp("flush_level", 8'(level), 8'd0);

    // Asynchronous reset in the middle of a fill, away from any clock edge.
    step("mid_fill", 1'b1, 1'b0, 1'b0);
    step("mid_fill", 1'b1, 1'b0, 1'b0);
    write_enable = 1'b0;
    #2;
    resetn = 1'b0;
    model_reset();
    sb.push_back(model_outputs());
    #1;
    check_pop("async_reset");
    @(negedge clock);
    resetn = 1'b1;

    // Random enables with occasional flush.
    for (int i = 0; i < 1000; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
